// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizing helpers for the truth-table scanner.
// Optional Gray-code vector ordering is selected with TT_SCAN_GRAY_EN (see truth_table_scanner.sv).
package tt_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    localparam int unsigned TT_N_IN_DEFAULT   = 32'd3;
    localparam int unsigned TT_SETTLE_DEFAULT = 32'd1;

    function automatic int unsigned tt_table_size(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // One extra bit so a fully wrong table (2^n errors) still fits.
    function automatic int unsigned tt_count_width(input int unsigned n);
        return n + 32'd1;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bus between the scanner and its environment: stimulus vector, circuit response,
// golden table, and the capture/result outputs.
interface truth_table_scanner_if
    import tt_scan_pkg::*;
#(
    parameter int unsigned N_IN = TT_N_IN_DEFAULT
) ();

    localparam int unsigned TBL = tt_table_size(N_IN);
    localparam int unsigned CW  = tt_count_width(N_IN);

    logic            start;
    logic            hold;
    logic            dut_in;
    logic [TBL-1:0]  expected;
    logic [N_IN-1:0] vec_out;
    logic [TBL-1:0]  table_out;
    logic            busy;
    logic            done;
    logic            mismatch;
    logic [CW-1:0]   err_count;

    modport master (
        output start, hold, dut_in, expected,
        input  vec_out, table_out, busy, done, mismatch, err_count
    );

    modport slave (
        input  start, hold, dut_in, expected,
        output vec_out, table_out, busy, done, mismatch, err_count
    );

endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle-interval counter: counts enabled cycles since clr and flags the final one.
module settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] limit,
    output logic       expire
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expire = ~clr & en & (cnt_q == (limit - 8'd1));

    // Next count: cleared, frozen while disabled, and never stepped past the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Clocked truth-table scanner: drives every input vector, samples the circuit after a
// settle interval, and compares against a golden table. Define TT_SCAN_GRAY_EN for Gray order.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int unsigned N_IN   = TT_N_IN_DEFAULT,
    parameter int unsigned SETTLE = TT_SETTLE_DEFAULT
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_scanner_if.slave bus
);

    localparam int unsigned     TBL        = tt_table_size(N_IN);
    localparam int unsigned     CW         = tt_count_width(N_IN);
    localparam logic [7:0]      SETTLE_LIM = 8'(SETTLE);
    localparam logic [N_IN-1:0] IDX_ZERO   = '0;
    localparam logic [N_IN-1:0] IDX_LAST   = '1;

`ifdef TT_SCAN_GRAY_EN
    function automatic logic [N_IN-1:0] vec_map(input logic [N_IN-1:0] i);
        return i ^ (i >> 1);
    endfunction
`else
    function automatic logic [N_IN-1:0] vec_map(input logic [N_IN-1:0] i);
        return i;
    endfunction
`endif

    tt_state_e       state_q, state_d;
    logic [N_IN-1:0] index_q, index_d;
    logic [N_IN-1:0] vec_out_q, vec_out_d;
    logic [TBL-1:0]  table_q, table_d;
    logic [CW-1:0]   err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            mismatch_q, mismatch_d;

    logic            timer_clr_s;
    logic            timer_expire_s;
    logic [N_IN-1:0] vec_sel_s;
    logic [N_IN-1:0] index_inc_s;

    // The timer only runs in SETTLE, so it starts every vector from zero.
    assign timer_clr_s = (state_q != ST_SETTLE);
    assign vec_sel_s   = vec_map(index_q);
    assign index_inc_s = index_q + 1'b1;

    settle_timer u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr_s),
        .en     (~bus.hold),
        .limit  (SETTLE_LIM),
        .expire (timer_expire_s)
    );

    // Scan sequencing, capture and result bookkeeping.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        vec_out_d  = vec_out_q;
        table_d    = table_q;
        err_d      = err_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_SETTLE;
                    index_d    = IDX_ZERO;
                    vec_out_d  = vec_map(IDX_ZERO);
                    table_d    = '0;
                    err_d      = '0;
                    mismatch_d = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_expire_s) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                // Table is indexed by vector value, so Gray order yields the same table.
                table_d[vec_sel_s] = bus.dut_in;
                if (bus.dut_in != bus.expected[vec_sel_s]) begin
                    err_d = err_q + 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (index_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    state_d   = ST_SETTLE;
                    index_d   = index_inc_s;
                    vec_out_d = vec_map(index_inc_s);
                end
            end
            ST_DONE: begin
                done_d     = 1'b1;
                mismatch_d = (err_q != '0);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any scan in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            vec_out_q  <= '0;
            table_q    <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            vec_out_q  <= vec_out_d;
            table_q    <= table_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign bus.vec_out   = vec_out_q;
    assign bus.table_out = table_q;
    assign bus.err_count = err_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.mismatch  = mismatch_q;

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Upstream stimulus stage and downstream capture stage for a small combinational gate-level circuit with N_IN inputs and 1 output.
- On start, steps vec_out through all 2^N_IN input combinations.
- Waits a settle interval on each vector, samples the circuit output, and builds the full truth table.
- Compares the result against an expected table and reports a mismatch count.
- Replaces hand-written delay-stepped testbench stimulus with a synthesizable, clocked scanner.

Parameters:
- N_IN, 3, number of circuit inputs; vec_out width; the table has 2^N_IN entries.
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a scan when the block is idle; ignored while busy.
- hold  in  1  freezes the settle counter while high.
- vec_out  out  N_IN  input vector driven to the circuit under scan; bit N_IN-1 is the MSB (A in a 3-input circuit).
- dut_in  in  1  circuit output, sampled in the SAMPLE state.
- expected  in  2^N_IN  golden table; bit i is the expected output for vector value i.
- table_out  out  2^N_IN  captured table; bit i is the output sampled for vector value i.
- busy  out  1  high while in the SETTLE or SAMPLE state.
- done  out  1  one-cycle pulse when a scan ends.
- mismatch  out  1  high when err_count is nonzero; valid from the done pulse until the next start.
- err_count  out  N_IN+1  number of entries where table_out differs from expected (maximum 2^N_IN, so it never overflows).

Behaviour:
- Reset (asynchronous, active-high): state IDLE; vec_out=0, table_out=0, busy=0, done=0, mismatch=0, err_count=0, index=0, settle counter=0.
- Reset asserted mid-scan aborts immediately to these values. No partial results are retained.
- IDLE, start=1 at a rising edge:
  - clear table_out, err_count and mismatch;
  - set index=0 and settle counter=0;
  - go to SETTLE. busy=1 from the next cycle.
- SETTLE:
  - vec_out = map(index), held stable;
  - counter increments each cycle that hold=0 and freezes while hold=1;
  - when counter reaches SETTLE-1 with hold=0, go to SAMPLE.
- SAMPLE (exactly one cycle; hold is ignored):
  - table_out[map(index)] <= dut_in;
  - if dut_in != expected[map(index)], err_count increments;
  - if index == 2^N_IN-1, go to DONE; otherwise index+1, counter=0, go to SETTLE.
- DONE (one cycle):
  - done=1, busy=0;
  - mismatch = (final err_count != 0);
  - next state is IDLE.
- Outputs held after a scan: vec_out keeps the last vector; table_out, err_count and mismatch hold until the next start.
- Latency with hold=0: done goes high 1 + 2^N_IN*(SETTLE+1) cycles after the start edge. For N_IN=3 and SETTLE=1 this is 17 cycles.
- start in DONE or while busy is ignored. start in the cycle after DONE is accepted.
- expected is sampled live in each SAMPLE cycle. Changing it mid-scan affects only entries not yet sampled.
- Without the optional feature, map(i)=i (binary order, 0 to 2^N_IN-1).

Optional Feature:
- Macro: TT_SCAN_GRAY_EN.
- Defined: map(i) = i ^ (i>>1), so consecutive vectors differ in exactly one bit. This exposes single-input transition glitches.
  - table_out and expected remain indexed by vector value, so the captured table is identical to the binary-order scan.
  - For N_IN=3 the vec_out order is 0,1,3,2,6,7,5,4.
- Undefined: binary order. No Gray logic is synthesized.

Decomposition:
- Package tt_scan_pkg:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - default N_IN;
  - constant functions for table size (2^N) and count width (N+1).
- Sub-module settle_timer: holds the counter; inputs clr, en (=~hold), and the SETTLE limit; output expire.
- FSM, index register, order map and capture logic stay in truth_table_scanner.

Test Plan:
All scenarios use N_IN=3. The circuit under scan is X = ~(((B^C)&A) | ~A), equivalent to A & ~(B^C).
- Full scan, SETTLE=1, expected=8'h90, start pulsed at cycle 0:
  - vec_out steps 0..7, two cycles each;
  - done at cycle 17; table_out=8'h90, err_count=0, mismatch=0.
- Same scan with expected=8'h91:
  - table_out=8'h90, err_count=1, mismatch=1 at done.
- hold=1 for 5 cycles during vector 3's SETTLE:
  - vec_out stays 3 for 7 cycles;
  - done at cycle 22; table_out=8'h90.
- start re-pulsed at cycle 6:
  - ignored; index unaffected; done at cycle 17.
- rst raised at cycle 9:
  - all outputs 0 immediately;
  - a new start gives a clean 17-cycle scan with table_out=8'h90.
- With TT_SCAN_GRAY_EN defined:
  - vec_out sequence is 0,1,3,2,6,7,5,4;
  - table_out=8'h90, err_count=0.
